// File: rtl/fifo_wr_front_if.sv
// Bundle of the write-domain front end signals: producer stream, FIFO write
// port, pointer inputs and level outputs.
//
// Handshake: a word on s_data transfers on a wclk edge where s_valid and
// s_ready are both high. On the FIFO side a word leaves on an edge where
// winc is high and wfull is low; winc while wfull is high moves nothing and
// wdata stays put.
interface fifo_wr_front_if #(
    parameter int DSIZE    = 8,
    parameter int ADDRSIZE = 9
);
    logic                s_valid;
    logic [DSIZE-1:0]    s_data;
    logic                s_ready;
    logic                winc;
    logic [DSIZE-1:0]    wdata;
    logic                wfull;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                walmost_full;

    // Environment side: producer plus write-pointer logic.
    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wlevel, walmost_full
    );

    // The front end block itself.
    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wlevel, walmost_full
    );
endinterface

// File: rtl/fifo_wr_front.sv
// Write-domain front end of the async FIFO: two-entry skid buffer between the
// producer stream and the FIFO write port, plus a registered fill level and
// almost-full flag derived from the Gray write/read pointers.
module fifo_wr_front #(
    parameter int DSIZE        = 8,
    parameter int ADDRSIZE     = 9,
    parameter int AFULL_THRESH = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    fifo_wr_front_if.slave   bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [ADDRSIZE:0] AFULL_LEVEL =
        (ADDRSIZE+1)'((1 << ADDRSIZE) - AFULL_THRESH);

    state_t             state, state_d;
    logic [DSIZE-1:0]   head, head_d;
    logic [DSIZE-1:0]   tail, tail_d;
    logic               s_ready_q;
    logic               winc_int;
    logic               accept;
    logic               pop;
    logic [ADDRSIZE:0]  wbin;
    logic [ADDRSIZE:0]  rbin;
    logic [ADDRSIZE:0]  level_d;
    logic [ADDRSIZE:0]  level_q;
    logic               afull_q;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign winc_int = (state != ST_EMPTY);
    assign accept   = bus.s_valid & s_ready_q;
    assign pop      = winc_int & ~bus.wfull;

    assign bus.s_ready      = s_ready_q;
    assign bus.winc         = winc_int;
    assign bus.wdata        = head;
    assign bus.wlevel       = level_q;
    assign bus.walmost_full = afull_q;
    assign dbg_state        = state;

    // Skid buffer next state: head always holds the oldest word.
    always_comb begin
        state_d = state;
        head_d  = head;
        tail_d  = tail;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_d  = bus.s_data;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_d = bus.s_data;
                end else if (accept) begin
                    state_d = ST_TWO;
                    tail_d  = bus.s_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = tail;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Skid buffer registers; s_ready is registered from the next occupancy.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= ST_EMPTY;
            head      <= '0;
            tail      <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state     <= state_d;
            head      <= head_d;
            tail      <= tail_d;
            s_ready_q <= (state_d != ST_TWO);
        end
    end

    // Occupancy from binary pointers; the extra MSB absorbs pointer wrap.
    always_comb begin
        wbin    = gray2bin(bus.wptr);
        rbin    = gray2bin(bus.wq2_rptr);
        level_d = wbin - rbin;
    end

    // Level and almost-full are registered together from the same level.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= (level_d >= AFULL_LEVEL);
        end
    end

endmodule

// File: tb/tb_fifo_wr_front.sv
// Bench for fifo_wr_front: directed scenarios plus a randomized run, checked
// against a queue model of the skid buffer and arithmetic pointer levels.
module tb_fifo_wr_front;

    localparam int DSIZE        = 8;
    localparam int ADDRSIZE     = 4;
    localparam int AFULL_THRESH = 4;
    localparam int DEPTH        = 1 << ADDRSIZE;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic [1:0] dbg_state;

    fifo_wr_front_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

    fifo_wr_front #(
        .DSIZE(DSIZE),
        .ADDRSIZE(ADDRSIZE),
        .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 wclk = ~wclk;

    int checks = 0;
    int failures = 0;

    // Model: words accepted but not yet written, oldest first.
    logic [DSIZE-1:0] exp_q[$];
    bit               m_ready;

    function automatic logic [ADDRSIZE:0] to_gray(input int b);
        logic [ADDRSIZE:0] v;
        v = (ADDRSIZE+1)'(b);
        return v ^ (v >> 1);
    endfunction

    // Drive one cycle from a negedge to the next, updating the model.
    task automatic drive_cycle(input bit v, input logic [DSIZE-1:0] d, input bit f);
        bit acc;
        bit pp;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.wfull   = f;
        acc = v && m_ready;
        pp  = (exp_q.size() != 0) && !f;
        @(posedge wclk);
        if (pp) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(d);
        m_ready = (exp_q.size() < 2);
        @(negedge wclk);
    endtask

    task automatic set_ptrs(input int w, input int r);
        bus.wptr     = to_gray(w);
        bus.wq2_rptr = to_gray(r);
    endtask

    task automatic apply_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.wfull   = 1'b0;
        set_ptrs(0, 0);
        wrst_n = 1'b0;
        exp_q.delete();
        m_ready = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready);
        end
        checks++;
        if (bus.winc !== 1'b0 || bus.wdata !== 8'h00) begin
            failures++; $display("FAIL reset_winc: got winc=%b wdata=%h expected 0/00", bus.winc, bus.wdata);
        end
        checks++;
        if (bus.wlevel !== 5'd0 || bus.walmost_full !== 1'b0 || dbg_state !== 2'd0) begin
            failures++; $display("FAIL reset_level: got lvl=%0d af=%b st=%0d expected 0/0/0",
                                 bus.wlevel, bus.walmost_full, dbg_state);
        end
        drive_cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_rise: got %b expected 1", bus.s_ready);
        end
    endtask

    task automatic test_stream();
        int winc_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.s_ready !== 1'b1) begin
                failures++; $display("FAIL stream_ready c%0d: got %b expected 1", i, bus.s_ready);
            end
            checks++;
            if (bus.winc !== (exp_q.size() != 0)) begin
                failures++; $display("FAIL stream_winc c%0d: got %b expected %b", i, bus.winc, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (bus.wdata !== 8'(i)) begin
                    failures++; $display("FAIL stream_wdata c%0d: got %h expected %h", i, bus.wdata, 8'(i));
                end
            end
            if (bus.winc === 1'b1) winc_cycles++;
            drive_cycle(i < 8, 8'(i + 1), 1'b0);
        end
        checks++;
        if (winc_cycles != 8) begin
            failures++; $display("FAIL stream_winc_count: got %0d expected 8", winc_cycles);
        end
    endtask

    task automatic test_backpressure();
        logic [DSIZE-1:0] words[3];
        logic [DSIZE-1:0] got[$];
        int p = 0;
        words[0] = 8'hA0; words[1] = 8'hA1; words[2] = 8'hA2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.s_ready !== m_ready) begin
                failures++; $display("FAIL bp_ready c%0d: got %b expected %b", i, bus.s_ready, m_ready);
            end
            if (i >= 1) begin
                checks++;
                if (bus.winc !== 1'b1 || bus.wdata !== 8'hA0) begin
                    failures++; $display("FAIL bp_hold c%0d: got winc=%b wdata=%h expected 1/a0", i, bus.winc, bus.wdata);
                end
            end
            begin
                bit acc;
                acc = (p < 3) && m_ready;
                drive_cycle(p < 3, words[p < 3 ? p : 2], 1'b1);
                if (acc) p++;
            end
        end
        checks++;
        if (p != 2 || bus.s_ready !== 1'b0) begin
            failures++; $display("FAIL bp_stall: got accepted=%0d ready=%b expected 2/0", p, bus.s_ready);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.winc === 1'b1) got.push_back(bus.wdata);
            begin
                bit acc;
                acc = (p < 3) && m_ready;
                drive_cycle(p < 3, words[p < 3 ? p : 2], 1'b0);
                if (acc) p++;
            end
        end
        checks++;
        if (got.size() != 3) begin
            failures++; $display("FAIL bp_count: got %0d words expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== words[k]) begin
                    failures++; $display("FAIL bp_order w%0d: got %h expected %h", k, got[k], words[k]);
                end
            end
        end
    endtask

    task automatic test_level();
        set_ptrs(3, 29);
        #1;
        checks++;
        if (bus.wlevel !== 5'd0) begin
            failures++; $display("FAIL level_lag: got %0d expected 0", bus.wlevel);
        end
        drive_cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.wlevel !== 5'd6) begin
            failures++; $display("FAIL level_wrap: got %0d expected 6", bus.wlevel);
        end
        set_ptrs(16, 0);
        drive_cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.wlevel !== 5'd16 || bus.walmost_full !== 1'b1) begin
            failures++; $display("FAIL level_full: got lvl=%0d af=%b expected 16/1", bus.wlevel, bus.walmost_full);
        end
    endtask

    task automatic test_almost_full();
        int lv[3];
        bit ex[3];
        lv[0] = 11; lv[1] = 12; lv[2] = 13;
        ex[0] = 1'b0; ex[1] = 1'b1; ex[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_ptrs(20 + lv[k], 20);
            drive_cycle(1'b0, '0, 1'b0);
            checks++;
            if (bus.walmost_full !== ex[k] || bus.wlevel !== 5'(lv[k])) begin
                failures++; $display("FAIL afull lvl%0d: got af=%b lvl=%0d expected %b/%0d",
                                     lv[k], bus.walmost_full, bus.wlevel, ex[k], lv[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        set_ptrs(7, 2);
        drive_cycle(1'b1, 8'h5A, 1'b1);
        drive_cycle(1'b1, 8'h5B, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        checks++;
        if (bus.winc !== 1'b1 || bus.s_ready !== 1'b0 || bus.wlevel !== 5'd5) begin
            failures++; $display("FAIL mrst_pre: got winc=%b ready=%b lvl=%0d expected 1/0/5",
                                 bus.winc, bus.s_ready, bus.wlevel);
        end
        #2 wrst_n = 1'b0;
        #1;
        checks++;
        if (bus.winc !== 1'b0 || bus.s_ready !== 1'b0 || bus.wlevel !== 5'd0 || bus.wdata !== 8'h00) begin
            failures++; $display("FAIL mrst_async: got winc=%b ready=%b lvl=%0d wdata=%h expected 0/0/0/00",
                                 bus.winc, bus.s_ready, bus.wlevel, bus.wdata);
        end
        exp_q.delete();
        m_ready = 1'b0;
        bus.s_valid = 1'b0;
        bus.wfull = 1'b0;
        set_ptrs(0, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        drive_cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL mrst_ready: got %b expected 1", bus.s_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.winc !== 1'b0) begin
                failures++; $display("FAIL mrst_stale c%0d: got winc=%b expected 0", i, bus.winc);
            end
            drive_cycle(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_random();
        int exp_lvl = 0;
        for (int i = 0; i < 400; i++) begin
            int w;
            int l;
            checks++;
            if (bus.s_ready !== m_ready) begin
                failures++; $display("FAIL rnd_ready c%0d: got %b expected %b", i, bus.s_ready, m_ready);
            end
            checks++;
            if (bus.winc !== (exp_q.size() != 0)) begin
                failures++; $display("FAIL rnd_winc c%0d: got %b expected %b", i, bus.winc, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (bus.wdata !== exp_q[0]) begin
                    failures++; $display("FAIL rnd_wdata c%0d: got %h expected %h", i, bus.wdata, exp_q[0]);
                end
            end
            if (i > 0) begin
                checks++;
                if (bus.wlevel !== 5'(exp_lvl) || bus.walmost_full !== (exp_lvl >= DEPTH - AFULL_THRESH)) begin
                    failures++; $display("FAIL rnd_level c%0d: got lvl=%0d af=%b expected %0d/%b", i,
                                         bus.wlevel, bus.walmost_full, exp_lvl, exp_lvl >= DEPTH - AFULL_THRESH);
                end
            end
            w = int'($urandom_range(0, 2 * DEPTH - 1));
            l = int'($urandom_range(0, DEPTH));
            set_ptrs(w, (w - l + 2 * DEPTH) % (2 * DEPTH));
            exp_lvl = l;
            drive_cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_level();
        test_almost_full();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_front.md
# fifo_wr_front

Write-domain front end of the asynchronous FIFO: accepts a valid/ready stream from the producer, buffers up to two words in a skid buffer, and drives `winc`/`wdata` into the write-pointer/full logic and the FIFO memory. It also converts the Gray write pointer and the synchronized Gray read pointer to binary to report a registered fill level and an almost-full flag. The block sits directly upstream of the write-pointer/full-generation stage and is fully synchronous to `wclk`.

## Interface
- `DSIZE`, 8, data word width
- `ADDRSIZE`, 9, FIFO address width; depth = 2^ADDRSIZE
- `AFULL_THRESH`, 4, `walmost_full` asserts when free slots <= this value (1..2^ADDRSIZE)

- `wclk`  in  1  write clock
- `wrst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  producer word valid
- `s_data`  in  DSIZE  producer word
- `s_ready`  out  1  block can accept a word this cycle (registered)
- `winc`  out  1  write request to FIFO; word on `wdata`
- `wdata`  out  DSIZE  head word of skid buffer
- `wfull`  in  1  registered full flag from write-pointer logic
- `wptr`  in  ADDRSIZE+1  Gray write pointer from write-pointer logic
- `wq2_rptr`  in  ADDRSIZE+1  Gray read pointer synchronized into wclk domain
- `wlevel`  out  ADDRSIZE+1  FIFO occupancy, 0..2^ADDRSIZE (registered)
- `walmost_full`  out  1  `wlevel >= 2^ADDRSIZE - AFULL_THRESH` (registered)

## Operation
- accept = `s_valid & s_ready`; pop = `winc & ~wfull`. Only pop removes a word; `winc` while `wfull` is a no-op and the word is held.
- Skid buffer: two entries, head and tail, occupancy count 0..2.
  - EMPTY (0): accept -> ONE, word to head.
  - ONE (1): accept & ~pop -> TWO (word to tail); pop & ~accept -> EMPTY; accept & pop -> ONE, new word to head.
  - TWO (2): pop -> ONE, tail moves to head; accept impossible (`s_ready`=0).
- `winc` = count != 0 (decoded from registered state); `wdata` = head entry. Both stable until pop.
- `s_ready` is a flop loaded with (next count < 2).
- Ordering: words leave in acceptance order; no drop, no duplicate.
- Level: Gray-to-binary convert `wptr` and `wq2_rptr` (bit i = XOR of bits ADDRSIZE..i); `wlevel` = (wbin − rbin) mod 2^(ADDRSIZE+1). Value 2^ADDRSIZE means full; the MSB difference handles pointer wrap.
- `walmost_full` compares the same-cycle computed level; both flags are registered together.
- `wlevel` is conservative: the read pointer arrives via a 2-flop synchronizer, so the level may over-report and never under-reports.

## Timing
- Reset values: `s_ready`=0, `winc`=0, `wdata`=0, count=0, `wlevel`=0, `walmost_full`=0. `s_ready` rises on the first `wclk` edge after `wrst_n` deasserts.
- Reset mid-operation: buffered words are discarded immediately; outputs take reset values asynchronously.
- Latency: accept at edge N -> `winc`=1 with the word on `wdata` after edge N (visible in cycle N+1).
- Throughput: one word per cycle while `wfull`=0. `s_ready` never drops while count stays <= 1.
- Backpressure: `wfull` high -> buffer fills to 2 -> `s_ready`=0 from the next cycle. The second word is always captured (skid).
- `wlevel`/`walmost_full` lag their pointer inputs by one `wclk`. The inputs lag pop by one cycle through the write-pointer logic, and read activity by 2+ cycles.
- Simultaneous accept and pop in state ONE: count unchanged, head replaced, `winc` stays 1.

## Test plan
- Reset then stream: ADDRSIZE=4, `wfull`=0, send 0x01..0x08 back-to-back -> `winc` high 8 consecutive cycles starting one cycle after the first accept; `wdata` = 0x01..0x08 in order; `s_ready` constant 1.
- Backpressure: hold `wfull`=1, offer 0xA0, 0xA1, 0xA2 -> 0xA0 and 0xA1 accepted, `s_ready`=0 one cycle later, 0xA2 held by the producer. Release `wfull` -> 0xA0, 0xA1, 0xA2 written in order with no loss.
- Level/wrap: drive Gray `wptr` = gray(3) and `wq2_rptr` = gray(29) (ADDRSIZE=4) -> `wlevel`=6. Drive `wptr`=gray(16), `wq2_rptr`=gray(0) -> `wlevel`=16.
- Almost-full: AFULL_THRESH=4, depth 16, level stepped 11 -> 12 -> 13 -> `walmost_full` 0, then 1, then 1, each one cycle after the pointer change.
- Mid-stream reset: two words buffered, assert `wrst_n`=0 asynchronously -> `winc`, `s_ready`, `wlevel` go 0 immediately. After release, `s_ready`=1 after one edge and no stale word appears on `winc`.
